// File: rtl/mlaccel_sspi_pkg.sv
`timescale 1ns/1ps
// mlaccel_sspi_pkg: shared state encoding and
// constants for the SPI responder slice.
package mlaccel_sspi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_SEL_WAIT = 2'd1;
  localparam state_t ST_SHIFT    = 2'd2;

  localparam logic [7:0] UNDERRUN_FILL = 8'h00;

  localparam logic CSB_IDLE  = 1'b1;
  localparam logic CLK_IDLE  = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/mlaccel_sspi_responder_if.sv
`timescale 1ns/1ps
// mlaccel_sspi_responder_if: core-side byte
// stream between the SPI responder and its user.
interface mlaccel_sspi_responder_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_underrun;
  logic       xfer_end;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  rx_first,
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_underrun,
    input  xfer_end
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output rx_first,
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_underrun,
    output xfer_end
  );

endinterface

// File: rtl/mlaccel_sspi_sync.sv
`timescale 1ns/1ps
// mlaccel_sspi_sync: input synchronizer followed by
// either a glitch filter or a matching delay line.
module mlaccel_sspi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 2,
  parameter bit   FILTER      = 1'b0,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_LEN-1:0]    hist;

  // Metastability chain; first flop sees the pin.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Sample history: filter window or plain delay.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hist <= {FILT_LEN{RST_VAL}};
    end else begin
      hist[0] <= sync[SYNC_STAGES-1];
      for (int i = 1; i < FILT_LEN; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  if (FILTER) begin : g_filt
    logic filt;

    // Held level; q shows the accepted level early
    // so edges line up with the delayed data path.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        filt <= RST_VAL;
      end else begin
        filt <= q;
      end
    end

    assign q = (&hist)  ? 1'b1 :
               (~|hist) ? 1'b0 : filt;
  end else begin : g_dly
    assign q = hist[FILT_LEN-1];
  end

endmodule

// File: rtl/mlaccel_sspi_responder.sv
`timescale 1ns/1ps
// mlaccel_sspi_responder: mode-3 SPI byte responder
// with a one-entry transmit holding buffer.
module mlaccel_sspi_responder
  import mlaccel_sspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic spi_csb,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  mlaccel_sspi_responder_if.slave core
);

  localparam int SETTLE = SYNC_STAGES + FILT_LEN;

  logic       csb_s;
  logic       clk_s;
  logic       mosi_s;
  logic       clk_d;
  logic       clk_rise;
  logic       clk_fall;
  state_t     state;
  logic       armed;
  logic [7:0] settle;
  logic       settled;
  logic       selected;
  logic       first_pend;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic [7:0] tx_sr;
  logic [7:0] hold_data;
  logic       hold_full;
  logic       tx_underrun;
  logic       xfer_end;
  logic       boundary;
  logic       accept;

  mlaccel_sspi_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN),
    .FILTER      (1'b0),
    .RST_VAL     (CSB_IDLE)
  ) u_csb (
    .clock  (clock),
    .resetn (resetn),
    .d      (spi_csb),
    .q      (csb_s)
  );

  mlaccel_sspi_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN),
    .FILTER      (1'b1),
    .RST_VAL     (CLK_IDLE)
  ) u_clk (
    .clock  (clock),
    .resetn (resetn),
    .d      (spi_clk),
    .q      (clk_s)
  );

  mlaccel_sspi_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN),
    .FILTER      (1'b0),
    .RST_VAL     (MOSI_IDLE)
  ) u_mosi (
    .clock  (clock),
    .resetn (resetn),
    .d      (spi_mosi),
    .q      (mosi_s)
  );

  assign clk_rise = clk_s & ~clk_d;
  assign clk_fall = ~clk_s & clk_d;
  assign settled  = (settle == 8'(SETTLE));
  assign selected = ~csb_s & (state != ST_IDLE);
  assign boundary = selected & clk_fall &
                    (bit_cnt == 3'd0);
  assign accept   = core.tx_valid & ~hold_full;

  // Previous filtered clock level for edge detect.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_d <= CLK_IDLE;
    end else begin
      clk_d <= clk_s;
    end
  end

  // Selection FSM; after reset the select line has
  // to be seen high once the synchronizers have
  // flushed before a new selection is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      armed  <= 1'b0;
      settle <= '0;
    end else begin
      if (!settled) settle <= settle + 8'd1;
      if (csb_s) begin
        state <= ST_IDLE;
        if (settled) armed <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (armed) state <= ST_SEL_WAIT;
          end
          ST_SEL_WAIT: begin
            if (clk_fall) state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            state <= ST_SHIFT;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Receive shifter, bit counter and byte strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      if (state == ST_IDLE) first_pend <= 1'b1;
      if (csb_s) begin
        bit_cnt <= '0;
      end else if (clk_rise &&
                   state == ST_SHIFT) begin
        rx_sr   <= {rx_sr[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data    <= {rx_sr, mosi_s};
          rx_valid   <= 1'b1;
          rx_first   <= first_pend;
          first_pend <= 1'b0;
        end
      end
    end
  end

  // Transmit shifter and one-entry holding buffer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_sr       <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (boundary) begin
        if (hold_full) begin
          tx_sr <= hold_data;
        end else begin
          tx_sr       <= UNDERRUN_FILL;
          tx_underrun <= 1'b1;
        end
      end else if (selected && clk_fall) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= core.tx_data;
      end else if (boundary) begin
        hold_full <= 1'b0;
      end
    end
  end

  // End-of-selection strobe on deselect.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      xfer_end <= 1'b0;
    end else begin
      xfer_end <= csb_s & (state != ST_IDLE);
    end
  end

  assign spi_miso         = tx_sr[7];
  assign spi_miso_oe      = (state != ST_IDLE);
  assign core.rx_valid    = rx_valid;
  assign core.rx_data     = rx_data;
  assign core.rx_first    = rx_first;
  assign core.tx_ready    = ~hold_full;
  assign core.tx_underrun = tx_underrun;
  assign core.xfer_end    = xfer_end;

endmodule

// File: doc/mlaccel_sspi_responder.md
MLACCEL_SSPI_RESPONDER -- requirements
Module: mlaccel_sspi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth applied to spi_csb, spi_clk and spi_mosi.
REQ-002 SHALL have parameter FILT_LEN, default 2: consecutive identical synchronized spi_clk samples required before a level change is accepted.
REQ-003 SHALL have port clock  in  1  system clock; the block has one clock, all logic runs on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port spi_csb  in  1  chip select from the host, active low, asynchronous to clock.
REQ-006 SHALL have port spi_clk  in  1  host SPI clock, mode 3 (idles high), asynchronous to clock.
REQ-007 SHALL have port spi_mosi  in  1  host-to-device data, MSB first.
REQ-008 SHALL have port spi_miso  out  1  device-to-host data, MSB first.
REQ-009 SHALL have port spi_miso_oe  out  1  output enable for the spi_miso pad; 1 only while selected.
REQ-010 SHALL have port rx_valid  out  1  one-cycle pulse: rx_data holds a complete received byte.
REQ-011 SHALL have port rx_data  out  8  last complete received byte.
REQ-012 SHALL have port rx_first  out  1  qualifies rx_valid: byte is the first of the current selection.
REQ-013 SHALL have port tx_valid  in  1  core offers tx_data.
REQ-014 SHALL have port tx_data  in  8  next byte to transmit.
REQ-015 SHALL have port tx_ready  out  1  1 while the one-entry transmit holding buffer is empty.
REQ-016 SHALL have port tx_underrun  out  1  one-cycle pulse: a byte boundary found the holding buffer empty.
REQ-017 SHALL have port xfer_end  out  1  one-cycle pulse on the accepted spi_csb rising edge.

Function
REQ-018 SHALL register spi_csb, spi_clk and spi_mosi through SYNC_STAGES flops before any use.
REQ-019 SHALL accept a new filtered spi_clk level only after FILT_LEN consecutive equal samples, so pulses shorter than FILT_LEN clocks (e.g. 1 ns glitches) produce no edge.
REQ-020 SHALL delay spi_mosi to match the spi_clk filter latency, so the sampled bit is the one present at the pin edge.
REQ-021 SHALL have states IDLE (csb high), SEL_WAIT (csb low, no clock edge yet) and SHIFT (byte in progress).
REQ-022 Transitions: IDLE->SEL_WAIT on synced csb low; SEL_WAIT->SHIFT on the first filtered falling edge; any state->IDLE on synced csb high.
REQ-023 SHALL shift spi_mosi into an 8-bit receive register on each filtered rising edge in SHIFT; a 3-bit counter wraps 7->0.
REQ-024 On the 8th rising edge SHALL update rx_data and pulse rx_valid on the next clock (latency SYNC_STAGES+FILT_LEN+1 clocks from the pin edge).
REQ-025 SHALL assert rx_first with the first rx_valid after entry to SEL_WAIT, and deassert it for all later bytes.
REQ-026 SHALL drive spi_miso from the MSB of the transmit shift register, shifting left on each filtered falling edge except the one at a byte boundary.
REQ-027 At each byte boundary (first falling edge of a byte), if the holding buffer is full, SHALL load the shift register from it and set tx_ready.
REQ-028 At a byte boundary with the holding buffer empty, SHALL load 0x00 and pulse tx_underrun.
REQ-029 SHALL accept tx_data into the holding buffer when tx_valid and tx_ready are both 1; if acceptance and boundary unload fall in the same cycle, the unload SHALL take the current buffer contents (empty means underrun) and the new byte SHALL remain in the buffer.
REQ-030 SHALL drive spi_miso_oe = 1 in SEL_WAIT and SHIFT, and 0 in IDLE.
REQ-031 On csb high mid-byte SHALL discard the partial byte (no rx_valid), clear the bit counter, pulse xfer_end and keep the holding buffer contents.
REQ-032 A 0-bit selection (csb low then high with no clock) SHALL produce only xfer_end.

Reset
REQ-033 On resetn low, asynchronously, SHALL go to IDLE; synchronizers load idle levels (csb=1, clk=1, mosi=0).
REQ-034 On resetn low, SHALL set rx_data=0x00, spi_miso=0, spi_miso_oe=0 and the pulse outputs rx_valid, rx_first, tx_underrun, xfer_end to 0.
REQ-035 On resetn low, SHALL empty the holding buffer (tx_ready=1).
REQ-036 Reset assertion mid-transfer SHALL abort it; after resetn deasserts, the block SHALL wait for a fresh csb falling edge.

Structure
REQ-037 Shared package mlaccel_sspi_pkg SHALL hold the state enum and the 0x00 underrun fill byte.
REQ-038 Synchronizer plus clock filter SHALL be one sub-module, mlaccel_sspi_sync, instantiated once per input.

Verification
REQ-039 Send 0x21, 0x05 with 17 ns half-periods -> two rx_valid pulses with rx_data 0x21 (rx_first=1) then 0x05 (rx_first=0).
REQ-040 Preload tx_data 0xA5, clock 8 bits -> host samples 10100101 on spi_miso after each falling edge; tx_ready rises at the boundary.
REQ-041 Send byte 0x23 with a 1 ns low glitch inserted in every second clock high phase -> exactly one rx_valid with 0x23.
REQ-042 Empty holding buffer, clock one byte -> spi_miso all 0 and one tx_underrun pulse.
REQ-043 Raise csb after 5 bits -> no rx_valid, one xfer_end pulse; the next selection's first byte carries rx_first=1.
REQ-044 Assert resetn low mid-byte -> outputs at reset values immediately; bytes received correctly after release and a new selection.
